axis_pixel_cipher: RTL and testbench
====================================

// Module: axis_pixel_cipher
// PURPOSE
//  Multi-lane AXI-Stream pixel cipher, the next generation of the Lorenz-keyed encryptor.
//  Sits between the pixel source and the sink, consuming one keystream beat per pixel beat.
//  Adds header pass-through, frame counting with TLAST/done, and encrypt/decrypt modes:
//  bypass, XOR, and chained diffusion.
// PARAMETERS
//  DATA_W       8       bits per lane (one colour component)
//  LANES        3       lanes per beat (3 = BGR pixel); bus width W = LANES*DATA_W
//  FRAME_BEATS  262144  beats per frame, header included in the count (512x512)
//  HDR_BEATS    18      leading beats per frame passed unmodified (54-byte BMP header / 3)
// PORTS
//  clk            in   1    clock, rising edge
//  rst_n          in   1    asynchronous active-low reset
//  cfg_mode       in   2    00 bypass, 01 XOR, 10 chain-encrypt, 11 chain-decrypt
//  cfg_iv         in   W    chain seed per lane
//  frame_abort    in   1    synchronous abort of current frame
//  s_pix_tdata    in   W    plaintext/ciphertext beat
//  s_pix_tvalid   in   1
//  s_pix_tready   out  1
//  s_pix_tlast    in   1    source end-of-frame marker
//  s_key_tdata    in   W    keystream, one key byte per lane
//  s_key_tvalid   in   1
//  s_key_tready   out  1
//  m_out_tdata    out  W    result beat
//  m_out_tvalid   out  1
//  m_out_tready   in   1
//  m_out_tlast    out  1    high on beat FRAME_BEATS-1 or on the source's early TLAST
//  done           out  1    1-cycle pulse when the last beat of a frame is accepted downstream
//  err_len        out  1    1-cycle pulse on a frame-length mismatch
// BEHAVIOUR
//  - Reset: all outputs 0. beat_cnt=0. chain regs=0. Skid buffer empty. Latched mode=00.
//  - Header vs body beat: a beat is a header beat if beat_cnt < HDR_BEATS, or if the
//    latched mode is 00. All other beats are body beats.
//  - Handshake: a header beat fires on s_pix valid&ready and does not consume a key.
//    A body beat fires only when s_pix_tvalid & s_key_tvalid & buffer-not-full.
//    Both streams are accepted in the same cycle.
//  - Readies: s_key_tready = s_pix_tvalid & body beat & buffer-not-full.
//    The key is never consumed alone. No ready depends combinationally on m_out_tready:
//    the skid buffer breaks that path.
//  - Latency and throughput: 1 cycle from input fire to m_out_tvalid. Sustains 1 beat/cycle
//    when m_out_tready stays high.
//  - Per-lane arithmetic, mod 2^DATA_W, with k = key lane and c_prev = chain lane:
//    XOR:           o = p ^ k
//    chain-encrypt: o = (p ^ k) + c_prev; chain <= o
//    chain-decrypt: o = (p - c_prev) ^ k; chain <= p (the input ciphertext)
//  - Frame start (beat_cnt==0, first fire): latch cfg_mode and load chain <= cfg_iv.
//    cfg_* changes mid-frame are ignored.
//  - beat_cnt increments on each input fire and wraps to 0 after FRAME_BEATS-1 or on an
//    accepted s_pix_tlast. Width is clog2(FRAME_BEATS).
//  - Length checks:
//    s_pix_tlast before FRAME_BEATS-1: beat is marked m_out_tlast; err_len pulses; frame ends.
//    Beat FRAME_BEATS-1 without s_pix_tlast: m_out_tlast=1 anyway; err_len pulses.
//  - done pulses on the output handshake of the beat carrying m_out_tlast.
//  - frame_abort: beat_cnt<=0 and chain<=0 next cycle. Buffered output beats still drain.
//    An input fire in the same cycle is dropped, not counted.
//  - Backpressure: with m_out_tready low, m_out_tdata/tlast hold stable while tvalid is high.
//    Readies drop once both skid entries are full.
//  - Async reset mid-frame: everything returns to reset values immediately, with no
//    partial output.
// STRUCTURE
//  - axis_cipher_pkg: MODE_BYPASS/MODE_XOR/MODE_CHENC/MODE_CHDEC constants and a
//    lane-op function shared with future decryptor variants.
//  - Sub-module axis_skid_buf #(WIDTH=W+1): 2-entry registered skid buffer on the
//    output (tdata+tlast).
//  - Top level: beat counter, mode latch, per-lane generate loop of the cipher op and
//    chain register.
// TESTING
//  1. XOR, LANES=3: pix 0x112233, key 0xFFFFFF, beat 18 -> out 0xEEDDCC, one cycle after
//     the fire; the re-XOR round-trip restores the input.
//  2. Header: beats 0..17 with s_key_tvalid=0 -> all pass unmodified, s_key_tready stays 0,
//     and no keystream is consumed.
//  3. Chain-encrypt, iv 0x10, DATA_W=8 LANES=1 HDR=0: p 0x01,0x02 with k 0x00 -> out
//     0x11,0x13. Chain-decrypt of 0x11,0x13 -> 0x01,0x02.
//  4. Random m_out_tready (50%) and random key tvalid over 1 frame -> output equals the
//     reference model. No beat lost or duplicated. Data is stable under stall. Exactly one
//     done pulse.
//  5. FRAME_BEATS=8, s_pix_tlast on beat 5 -> m_out_tlast on beat 5, err_len=1, next beat
//     has beat_cnt=0 and cfg re-latched.
//  6. frame_abort at beat 100, then a fresh frame -> chain reloads cfg_iv. Also: rst_n low
//     mid-frame -> all outputs 0 and the buffer is empty.

Source files
------------

// File: rtl/axis_pixel_cipher_pkg.sv
// Shared definitions for the AXI-Stream pixel cipher family: cipher modes and the
// per-lane arithmetic, kept here so future decryptor variants reuse the same op.
package axis_pixel_cipher_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_XOR    = 2'b01,
    MODE_CHENC  = 2'b10,
    MODE_CHDEC  = 2'b11
  } mode_e;

  // Lanes are computed at this width and truncated by the caller; xor/add/sub
  // low bits depend only on operand low bits, so the result is exact mod 2^DATA_W.
  localparam int LANE_MAX_W = 32;
  typedef logic [LANE_MAX_W-1:0] lane_t;

  function automatic lane_t lane_op(input mode_e mode, input lane_t p, input lane_t k,
                                    input lane_t c);
    lane_t r;
    case (mode)
      MODE_XOR:   r = p ^ k;
      MODE_CHENC: r = (p ^ k) + c;
      MODE_CHDEC: r = (p - c) ^ k;
      default:    r = p;
    endcase
    return r;
  endfunction

  // Encrypt chains on its own output, decrypt chains on the incoming ciphertext.
  function automatic lane_t chain_next(input mode_e mode, input lane_t p, input lane_t o);
    return (mode == MODE_CHDEC) ? p : o;
  endfunction

endpackage

// File: rtl/axis_pixel_cipher_if.sv
// Pixel, keystream and result AXI-Stream channels of the cipher as one bundle.
// slave = cipher side, master = source/sink side.
interface axis_pixel_cipher_if #(
  parameter int W = 24
);
  logic [W-1:0] s_pix_tdata;
  logic         s_pix_tvalid;
  logic         s_pix_tready;
  logic         s_pix_tlast;
  logic [W-1:0] s_key_tdata;
  logic         s_key_tvalid;
  logic         s_key_tready;
  logic [W-1:0] m_out_tdata;
  logic         m_out_tvalid;
  logic         m_out_tready;
  logic         m_out_tlast;

  modport slave (
    input  s_pix_tdata, s_pix_tvalid, s_pix_tlast, s_key_tdata, s_key_tvalid, m_out_tready,
    output s_pix_tready, s_key_tready, m_out_tdata, m_out_tvalid, m_out_tlast
  );

  modport master (
    output s_pix_tdata, s_pix_tvalid, s_pix_tlast, s_key_tdata, s_key_tvalid, m_out_tready,
    input  s_pix_tready, s_key_tready, m_out_tdata, m_out_tvalid, m_out_tlast
  );
endinterface

// File: rtl/axis_skid_buf.sv
// 2-entry registered output buffer; its ready is a function of fill level only,
// so no upstream ready depends combinationally on the downstream ready.
module axis_skid_buf #(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);
  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_cnt;
  logic [1:0]       w_cnt_nxt;
  logic             w_push;
  logic             w_pop;

  assign o_ready = (r_cnt != 2'd2);
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_mem[r_rptr];
  assign w_push  = i_valid && o_ready;
  assign w_pop   = o_valid && i_ready;

  always_comb begin
    // NOTE: default first so every path assigns w_cnt_nxt; no latch is inferred.
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = r_cnt + 2'd1;
    else if (w_pop && !w_push) w_cnt_nxt = r_cnt - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two entries are reset so the output bus reads zero, never stale data.
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of order.
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_cnt <= w_cnt_nxt;
    end
  end
endmodule

// File: rtl/axis_pixel_cipher.sv
// Multi-lane AXI-Stream pixel cipher: header pass-through, per-frame mode/IV latch,
// XOR and chained encrypt/decrypt per lane, frame length checking, registered output.
module axis_pixel_cipher
  import axis_pixel_cipher_pkg::*;
#(
  parameter int  DATA_W      = 8,
  parameter int  LANES       = 3,
  parameter int  FRAME_BEATS = 262144,
  parameter int  HDR_BEATS   = 18,
  localparam int W           = LANES * DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cfg_mode,
  input  logic [W-1:0]          cfg_iv,
  input  logic                  frame_abort,
  axis_pixel_cipher_if.slave    bus,
  output logic                  done,
  output logic                  err_len
);
  localparam int CNT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BEATS - 1);

  logic             r_active;
  logic [CNT_W-1:0] r_beat_cnt;
  mode_e            r_mode;
  logic [W-1:0]     r_chain;

  logic             w_frame_start;
  logic             w_in_hdr;
  logic             w_hdr;
  logic             w_buf_ready;
  logic             w_fire;
  logic             w_push;
  logic             w_at_last;
  logic             w_last;
  logic             w_len_err;
  mode_e            w_mode;
  logic [W-1:0]     w_chain_cur;
  logic [W-1:0]     w_chain_nxt;
  logic [W-1:0]     w_data;
  logic [W:0]       w_out;

  // The first beat of a frame already runs with the configuration being latched.
  assign w_frame_start = (r_beat_cnt == '0);
  assign w_mode        = w_frame_start ? mode_e'(cfg_mode) : r_mode;
  assign w_chain_cur   = w_frame_start ? cfg_iv : r_chain;

  if (HDR_BEATS > 0) begin : g_hdr
    assign w_in_hdr = (r_beat_cnt < CNT_W'(HDR_BEATS));
  end else begin : g_no_hdr
    assign w_in_hdr = 1'b0;
  end

  assign w_hdr            = w_in_hdr || (w_mode == MODE_BYPASS);
  assign bus.s_pix_tready = r_active && w_buf_ready && (w_hdr || bus.s_key_tvalid);
  assign bus.s_key_tready = r_active && w_buf_ready && bus.s_pix_tvalid && !w_hdr;
  assign w_fire           = bus.s_pix_tvalid && bus.s_pix_tready;
  assign w_push           = w_fire && !frame_abort;
  assign w_at_last        = (r_beat_cnt == LAST_CNT);
  assign w_last           = w_at_last || bus.s_pix_tlast;
  assign w_len_err        = (w_at_last != bus.s_pix_tlast);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DATA_W-1:0] w_p;
    logic [DATA_W-1:0] w_k;
    logic [DATA_W-1:0] w_c;
    logic [DATA_W-1:0] w_o;

    assign w_p = bus.s_pix_tdata[g*DATA_W +: DATA_W];
    assign w_k = bus.s_key_tdata[g*DATA_W +: DATA_W];
    assign w_c = w_chain_cur[g*DATA_W +: DATA_W];
    assign w_o = DATA_W'(lane_op(w_mode, lane_t'(w_p), lane_t'(w_k), lane_t'(w_c)));

    assign w_data[g*DATA_W +: DATA_W]      = w_hdr ? w_p : w_o;
    assign w_chain_nxt[g*DATA_W +: DATA_W] =
      w_hdr ? w_c : DATA_W'(chain_next(w_mode, lane_t'(w_p), lane_t'(w_o)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active   <= 1'b0;
      r_beat_cnt <= '0;
      r_mode     <= MODE_BYPASS;
      r_chain    <= '0;
      done       <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      r_active <= 1'b1;
      done     <= bus.m_out_tvalid && bus.m_out_tready && bus.m_out_tlast;
      err_len  <= w_push && w_len_err;
      if (frame_abort) begin
        r_beat_cnt <= '0;
        r_chain    <= '0;
      end else if (w_fire) begin
        if (w_frame_start) r_mode <= mode_e'(cfg_mode);
        r_chain    <= w_chain_nxt;
        r_beat_cnt <= w_last ? '0 : r_beat_cnt + CNT_W'(1);
      end
    end
  end

  axis_skid_buf #(
    .WIDTH (W + 1)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  ({w_last, w_data}),
    .i_valid (w_push),
    .o_ready (w_buf_ready),
    .o_data  (w_out),
    .o_valid (bus.m_out_tvalid),
    .i_ready (bus.m_out_tready)
  );

  assign bus.m_out_tlast = w_out[W];
  assign bus.m_out_tdata = w_out[W-1:0];
endmodule

// File: tb/tb_axis_pixel_cipher.sv
// Directed bench: a 3-lane cipher with an 18-beat header and a 1-lane short-frame
// cipher, with expected results computed by hand or by a small reference model.
module tb_axis_pixel_cipher;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  cfg_mode_a, cfg_mode_b;
  logic [23:0] cfg_iv_a;
  logic [7:0]  cfg_iv_b;
  logic        abort_a, abort_b;
  logic        done_a, done_b, err_a, err_b;

  axis_pixel_cipher_if #(.W(24)) ifa ();
  axis_pixel_cipher_if #(.W(8))  ifb ();

  axis_pixel_cipher #(
    .DATA_W(8), .LANES(3), .FRAME_BEATS(128), .HDR_BEATS(18)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode_a), .cfg_iv(cfg_iv_a),
    .frame_abort(abort_a), .bus(ifa), .done(done_a), .err_len(err_a)
  );

  axis_pixel_cipher #(
    .DATA_W(8), .LANES(1), .FRAME_BEATS(8), .HDR_BEATS(0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode_b), .cfg_iv(cfg_iv_b),
    .frame_abort(abort_b), .bus(ifb), .done(done_b), .err_len(err_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_a(input logic [23:0] p, input logic [23:0] k, input logic kv,
                        input logic lst, output logic kr);
    int n;
    @(negedge clk);
    ifa.s_pix_tdata  = p;
    ifa.s_key_tdata  = k;
    ifa.s_key_tvalid = kv;
    ifa.s_pix_tlast  = lst;
    ifa.s_pix_tvalid = 1'b1;
    #1;
    n = 0;
    while (!ifa.s_pix_tready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n == 20) check("push_a_timeout", ifa.s_pix_tready, 1);
    kr = ifa.s_key_tready;
    @(posedge clk);
    @(negedge clk);
    ifa.s_pix_tvalid = 1'b0;
    ifa.s_key_tvalid = 1'b0;
    ifa.s_pix_tlast  = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] p, input logic [7:0] k, input logic kv,
                        input logic lst, output logic kr);
    int n;
    @(negedge clk);
    ifb.s_pix_tdata  = p;
    ifb.s_key_tdata  = k;
    ifb.s_key_tvalid = kv;
    ifb.s_pix_tlast  = lst;
    ifb.s_pix_tvalid = 1'b1;
    #1;
    n = 0;
    while (!ifb.s_pix_tready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n == 20) check("push_b_timeout", ifb.s_pix_tready, 1);
    kr = ifb.s_key_tready;
    @(posedge clk);
    @(negedge clk);
    ifb.s_pix_tvalid = 1'b0;
    ifb.s_key_tvalid = 1'b0;
    ifb.s_pix_tlast  = 1'b0;
  endtask

  // Reference for the random frame: chain-encrypt, 18 header beats, 3 lanes.
  logic [23:0] t4_pix [128];
  logic [23:0] t4_key [128];
  logic [23:0] t4_exp [128];

  task automatic build_t4(input logic [23:0] iv);
    logic [7:0] c [3];
    logic [7:0] p, k, o;
    for (int l = 0; l < 3; l++) c[l] = iv[8*l +: 8];
    for (int i = 0; i < 128; i++) begin
      t4_pix[i] = 24'($urandom);
      t4_key[i] = 24'($urandom);
      if (i < 18) begin
        t4_exp[i] = t4_pix[i];
      end else begin
        for (int l = 0; l < 3; l++) begin
          p = t4_pix[i][8*l +: 8];
          k = t4_key[i][8*l +: 8];
          o = (p ^ k) + c[l];
          c[l] = o;
          t4_exp[i][8*l +: 8] = o;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic        kr;
  logic [23:0] pv;
  int          idx_in, idx_out, cyc, done_cnt, err_cnt;

  initial begin
    cfg_mode_a = 2'b00; cfg_iv_a = '0; abort_a = 1'b0;
    cfg_mode_b = 2'b00; cfg_iv_b = '0; abort_b = 1'b0;
    ifa.s_pix_tdata = '0; ifa.s_pix_tvalid = 0; ifa.s_pix_tlast = 0;
    ifa.s_key_tdata = '0; ifa.s_key_tvalid = 0; ifa.m_out_tready = 0;
    ifb.s_pix_tdata = '0; ifb.s_pix_tvalid = 0; ifb.s_pix_tlast = 0;
    ifb.s_key_tdata = '0; ifb.s_key_tvalid = 0; ifb.m_out_tready = 0;

    // Reset state
    #12;
    check("rst_out_valid", ifa.m_out_tvalid, 0);
    check("rst_out_data",  ifa.m_out_tdata, 0);
    check("rst_out_last",  ifa.m_out_tlast, 0);
    check("rst_pix_ready", ifa.s_pix_tready, 0);
    check("rst_key_ready", ifa.s_key_tready, 0);
    check("rst_done",      done_a, 0);
    check("rst_err_len",   err_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Header beats pass unmodified without a keystream
    cfg_mode_a = 2'b01;
    ifa.m_out_tready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      pv = 24'hA0_5000 | 24'(i);
      push_a(pv, 24'h0, 1'b0, 1'b0, kr);
      check("hdr_key_ready", kr, 0);
      check("hdr_valid", ifa.m_out_tvalid, 1);
      check("hdr_data", ifa.m_out_tdata, pv);
    end

    // XOR on beat 18, then re-XOR restores the input
    push_a(24'h112233, 24'hFFFFFF, 1'b1, 1'b0, kr);
    check("xor_key_ready", kr, 1);
    check("xor_valid", ifa.m_out_tvalid, 1);
    check("xor_data", ifa.m_out_tdata, 24'hEEDDCC);
    push_a(24'hEEDDCC, 24'hFFFFFF, 1'b1, 1'b0, kr);
    check("xor_roundtrip", ifa.m_out_tdata, 24'h112233);

    for (int i = 20; i < 100; i++) push_a(24'($urandom), 24'($urandom), 1'b1, 1'b0, kr);

    // Abort at beat 100: the beat fired alongside the abort is dropped
    @(negedge clk);
    ifa.s_pix_tdata = 24'h777777; ifa.s_key_tdata = 24'h0;
    ifa.s_pix_tvalid = 1'b1; ifa.s_key_tvalid = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0; ifa.s_pix_tvalid = 1'b0; ifa.s_key_tvalid = 1'b0;
    check("abort_drop", ifa.m_out_tvalid, 0);

    // Fresh chain-encrypt frame with random stalls; cfg changed mid-frame is ignored
    cfg_mode_a = 2'b10;
    cfg_iv_a   = 24'h5A3C81;
    build_t4(24'h5A3C81);
    idx_in = 0; idx_out = 0; cyc = 0; done_cnt = 0; err_cnt = 0;
    while (idx_out < 128 && cyc < 3000) begin
      @(negedge clk);
      if (ifa.m_out_tvalid) begin
        if (idx_out < 128) begin
          check("t4_data", ifa.m_out_tdata, t4_exp[idx_out]);
          check("t4_last", ifa.m_out_tlast, (idx_out == 127) ? 1 : 0);
        end else begin
          check("t4_extra_beat", ifa.m_out_tvalid, 0);
        end
      end
      if (done_a) done_cnt++;
      if (err_a) err_cnt++;
      if (idx_in == 5) begin
        cfg_iv_a   = 24'hFFFFFF;
        cfg_mode_a = 2'b01;
      end
      ifa.m_out_tready = 1'($urandom_range(0, 1));
      ifa.s_key_tvalid = 1'($urandom_range(0, 1));
      if (idx_in < 128) begin
        ifa.s_pix_tvalid = 1'b1;
        ifa.s_pix_tdata  = t4_pix[idx_in];
        ifa.s_key_tdata  = t4_key[idx_in];
        ifa.s_pix_tlast  = (idx_in == 127);
      end else begin
        ifa.s_pix_tvalid = 1'b0;
        ifa.s_pix_tlast  = 1'b0;
      end
      #1;
      if (ifa.m_out_tvalid && ifa.m_out_tready) idx_out++;
      if (ifa.s_pix_tvalid && ifa.s_pix_tready) idx_in++;
      cyc++;
    end
    ifa.s_pix_tvalid = 1'b0; ifa.s_key_tvalid = 1'b0; ifa.s_pix_tlast = 1'b0;
    ifa.m_out_tready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done_a) done_cnt++;
      if (err_a) err_cnt++;
    end
    check("t4_beats_in", idx_in, 128);
    check("t4_beats_out", idx_out, 128);
    check("t4_done_pulses", done_cnt, 1);
    check("t4_err_pulses", err_cnt, 0);
    check("t4_no_dup", ifa.m_out_tvalid, 0);

    // Fill both entries under backpressure, then reset mid-frame
    ifa.m_out_tready = 1'b0;
    @(negedge clk);
    ifa.s_pix_tdata = 24'h123456; ifa.s_pix_tvalid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("full_pix_ready", ifa.s_pix_tready, 0);
    check("full_out_valid", ifa.m_out_tvalid, 1);
    check("full_out_data", ifa.m_out_tdata, 24'h123456);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", ifa.m_out_tvalid, 0);
    check("midrst_data", ifa.m_out_tdata, 0);
    check("midrst_last", ifa.m_out_tlast, 0);
    check("midrst_pix_ready", ifa.s_pix_tready, 0);
    check("midrst_done", done_a, 0);
    @(negedge clk);
    ifa.s_pix_tvalid = 1'b0;
    ifa.m_out_tready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_empty", ifa.m_out_tvalid, 0);

    // Chain encrypt / decrypt, 1 lane, no header
    ifb.m_out_tready = 1'b1;
    cfg_mode_b = 2'b10; cfg_iv_b = 8'h10;
    push_b(8'h01, 8'h00, 1'b1, 1'b0, kr);
    check("chenc_0", ifb.m_out_tdata, 8'h11);
    push_b(8'h02, 8'h00, 1'b1, 1'b0, kr);
    check("chenc_1", ifb.m_out_tdata, 8'h13);
    @(negedge clk); abort_b = 1'b1;
    @(negedge clk); abort_b = 1'b0;
    cfg_mode_b = 2'b11;
    push_b(8'h11, 8'h00, 1'b1, 1'b0, kr);
    check("chdec_0", ifb.m_out_tdata, 8'h01);
    push_b(8'h13, 8'h00, 1'b1, 1'b0, kr);
    check("chdec_1", ifb.m_out_tdata, 8'h02);
    @(negedge clk); abort_b = 1'b1;
    @(negedge clk); abort_b = 1'b0;

    // Early TLAST on beat 5 of an 8-beat frame
    cfg_mode_b = 2'b01; cfg_iv_b = 8'h00;
    for (int i = 0; i < 6; i++) begin
      push_b(8'h40 + 8'(i), 8'h00, 1'b1, (i == 5), kr);
      check("early_data", ifb.m_out_tdata, 8'h40 + 8'(i));
      check("early_last", ifb.m_out_tlast, (i == 5) ? 1 : 0);
      check("early_err", err_b, (i == 5) ? 1 : 0);
    end
    @(negedge clk);
    check("early_done", done_b, 1);
    check("early_err_pulse", err_b, 0);

    // Next beat starts a new frame and re-latches cfg (bypass now)
    cfg_mode_b = 2'b00;
    push_b(8'h3C, 8'hFF, 1'b1, 1'b0, kr);
    check("relatch_key_ready", kr, 0);
    check("relatch_data", ifb.m_out_tdata, 8'h3C);

    // Beat FRAME_BEATS-1 without TLAST
    for (int i = 1; i < 8; i++) begin
      push_b(8'h50 + 8'(i), 8'hFF, 1'b1, 1'b0, kr);
      check("full_data", ifb.m_out_tdata, 8'h50 + 8'(i));
      check("full_last", ifb.m_out_tlast, (i == 7) ? 1 : 0);
      check("full_err", err_b, (i == 7) ? 1 : 0);
    end
    @(negedge clk);
    check("full_done", done_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
